// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter
//   Round-robin arbiter that gives one shared downstream resource to one of N
//   requesters at a time. A one-hot priority pointer starts at bit 0. When a
//   grant is released, the pointer moves to the bit just past the owner,
//   wrapping from bit N-1 back to bit 0.
//
//   Optional feature, enabled by defining ARB_TIMEOUT_EN:
//     An 8-bit hold counter forces a release once the owner has held the
//     grant for MAX_HOLD cycles while another requester is waiting. A forced
//     release raises timeout_o for one cycle.
//
// Ports
//   clk_i       rising-edge clock
//   rst_i       synchronous, active-high reset
//   req_i       level request for each requester
//   done_i      release strobe for each requester; only the owner's bit counts
//   gnt_o       registered one-hot grant; all zero when idle
//   busy_o      high while a grant is held
//   owner_id_o  binary index of the owner; 0 when idle
//   ptr_o       one-hot priority pointer (the highest-priority requester)
//   timeout_o   one-cycle pulse on a forced release
module ring_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         req_i,
  input  logic [N-1:0]         done_i,
  output logic [N-1:0]         gnt_o,
  output logic                 busy_o,
  output logic [$clog2(N)-1:0] owner_id_o,
  output logic [N-1:0]         ptr_o,
  output logic                 timeout_o
);

  localparam int IW = $clog2(N);
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          timeout_q, timeout_d;

  logic [N-1:0]  mask, masked, pick_src, win;
  logic [IW-1:0] win_idx;
  logic          owner_req, owner_done, others_req;
  logic          normal_rel, forced_rel, release_now;

  // Winner selection. First look at requests at or above the pointer. If
  // there are none, wrap around to the whole request vector. In both cases
  // the lowest set bit of the chosen vector wins.
  always_comb begin
    mask     = ~(ptr_q - N'(1));
    masked   = req_i & mask;
    pick_src = (|masked) ? masked : req_i;
    win      = pick_src & (~pick_src + N'(1));
    win_idx  = '0;
    for (int i = 0; i < N; i++) begin
      if (win[i]) win_idx = IW'(i);
    end
  end

  assign owner_req  = |(req_i & gnt_q);
  assign owner_done = |(done_i & gnt_q);
  assign others_req = |(req_i & ~gnt_q);
  assign normal_rel = owner_done | ~owner_req;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // The counter is held at zero while idle, so it starts from zero each time
  // a grant is entered. It saturates at 255.
  always_comb begin
    cnt_d = 8'd0;
    if (state_q == GRANT) cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  // Compare with >= so that a counter saturated by an uncontested owner still
  // releases as soon as a competing request appears.
  assign forced_rel = (cnt_q >= HOLD_LIM) & others_req;
`else
  logic unused_hold;
  assign unused_hold = ^HOLD_LIM;
  assign forced_rel  = 1'b0;
`endif

  assign release_now = normal_rel | forced_rel;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = GRANT;
          gnt_d   = win;
          owner_d = win_idx;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d   = IDLE;
          gnt_d     = '0;
          owner_d   = '0;
          ptr_d     = {gnt_q[N-2:0], gnt_q[N-1]};
          // A normal release on the same edge takes precedence, so no pulse.
          timeout_d = forced_rel & ~normal_rel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ptr_q     <= N'(1);
      owner_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign busy_o     = (state_q == GRANT);
  assign owner_id_o = owner_q;
  assign ptr_o      = ptr_q;
  assign timeout_o  = timeout_q;

endmodule

// File: doc/ring_rr_arbiter.md
# ring_rr_arbiter

Round-robin arbiter that shares one downstream resource among N requesters, using a one-hot rotating priority pointer with ring-counter semantics (reset to bit 0, rotate left with wrap). It sits in front of the shared datapath and issues exactly one registered grant at a time. It holds that grant until the owner releases it, then advances priority past the owner. An optional hold-timeout forces release when other requesters are starved.

## Interface
- N, default 4: number of requesters; legal range 2..16.
- MAX_HOLD, default 16: grant-hold limit in cycles, used only with the timeout feature; legal range 2..255.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request per requester; level-sensitive.
- done  input  N  release strobe per requester; only the owner's bit is honoured.
- gnt  output  N  one-hot grant, registered; all-zero when idle.
- busy  output  1  high while in GRANT state.
- owner_id  output  $clog2(N)  binary index of the current owner; 0 when idle.
- ptr  output  N  one-hot priority pointer; the highest-priority requester.
- timeout  output  1  one-cycle pulse on a forced release.

## Operation
- States: IDLE, GRANT. The two-state FSM is held in registers.
- Reset: state IDLE, gnt 0, busy 0, owner_id 0, ptr 1 (bit 0), timeout 0, hold counter 0.
- In IDLE with req != 0, the arbiter picks the first set req bit, searching from the ptr position upward and wrapping from bit N-1 to bit 0.
  - Next state is GRANT.
  - gnt is set one-hot to the winner, and owner_id is set to its index.
- In IDLE with req == 0, the arbiter stays in IDLE and ptr is unchanged.
- In GRANT, gnt, owner_id and ptr hold while req[owner]=1 and done[owner]=0.
- Release condition: done[owner]=1 or req[owner]=0. On release:
  - gnt clears to 0, busy clears to 0, owner_id clears to 0, and the state returns to IDLE.
  - ptr becomes gnt rotated left by one, wrapping bit N-1 to bit 0.
- done and req changes on non-owner bits during GRANT are ignored for the grant. Those requests are evaluated at the next IDLE.
- Never more than one gnt bit is high; ptr is always exactly one-hot.

## Timing
- Grant latency: req sampled high at edge k gives gnt high after edge k (visible in cycle k+1).
- Release latency: done or req drop sampled at edge m gives gnt low after edge m.
- Every release is followed by at least one IDLE cycle. The next grant is visible no earlier than after edge m+1.
- A back-to-back requester therefore sees a gnt gap of exactly one cycle.
- Simultaneous done[owner] and a new req from any bit: the release takes priority, and the new request is arbitrated in the following IDLE cycle.
- Reset asserted mid-GRANT: all outputs take their reset values after that edge, regardless of req and done.
- busy equals (state==GRANT) and is registered in the same cycle as gnt.

## Configuration
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle, saturating at 255.
  - Forced release happens when the counter reaches MAX_HOLD-1 and some other req bit is high. Forced release has the same effect as a normal release, plus timeout=1 for that one cycle.
  - If no other requester is pending, the grant is kept and the counter saturates.
  - A normal release on the same edge as a forced release produces no timeout pulse.
- Undefined: no counter is present, timeout is tied to 0, and a grant lasts until done or req drops.

## Test plan
- Reset then req=4'b0000 for 5 cycles -> gnt=0, busy=0, ptr=4'b0001 throughout.
- req=4'b1010 at cycle 0 -> gnt=4'b0010 at cycle 1. done[1] at cycle 4 -> gnt=0 at cycle 5, ptr=4'b0100, gnt=4'b1000 at cycle 6.
- All req held at 4'b1111 with each owner pulsing done 2 cycles after its grant -> grant order 0,1,2,3,0 with a one-cycle gap each time, and ptr wraps 4'b1000 to 4'b0001.
- Owner 2 granted, then done[0] and done[3] pulsed -> gnt stays 4'b0100. req[2] dropped -> gnt=0 on the next cycle.
- Reset asserted during GRANT with owner 3 -> next cycle gnt=0, ptr=4'b0001, busy=0.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0011 held, no done:
  - gnt=4'b0001 for exactly 4 cycles, then timeout=1 for one cycle with gnt=0, then gnt=4'b0010.
  - With req=4'b0001 only, the grant persists and timeout stays 0.
